// File: rtl/fifo_burst_reader_pkg.sv
// Shared types and helpers for the fifo_burst_reader burst controller.
package fifo_burst_reader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Default output-buffer depth and the matching pointer width.
  localparam int BDEPTH_DEF = 4;
  localparam int BPTR_W     = $clog2(BDEPTH_DEF);

  // Pointer width for an arbitrary power-of-2 buffer depth.
  function automatic int ptr_w(input int depth);
    return $clog2(depth);
  endfunction

endpackage

// File: rtl/fifo_burst_reader_sync_buf.sv
// Small single-clock FIFO that holds words returned by the upstream FIFO
// until the downstream consumer accepts them. Push and pop in the same cycle
// leave the occupancy unchanged.
module fifo_burst_reader_sync_buf
  import fifo_burst_reader_pkg::*;
#(
  parameter int DW    = 8,
  parameter int DEPTH = BDEPTH_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [DW-1:0]            din,
  input  logic                     pop,
  output logic [DW-1:0]            dout,
  output logic [ptr_w(DEPTH):0]    occ,
  output logic                     empty,
  output logic                     full
);

  localparam int PW = ptr_w(DEPTH);
  localparam int OW = PW + 1;

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW:0]   occ_q, occ_d;
  logic          do_push_s, do_pop_s;

  assign empty     = (occ_q == OW'(0));
  assign full      = (occ_q == OW'(DEPTH));
  assign occ       = occ_q;
  assign dout      = mem_q[rd_ptr_q];
  assign do_push_s = push && !full;
  assign do_pop_s  = pop && !empty;

  // Next-state of storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (do_push_s) begin
      mem_d[wr_ptr_q] = din;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   occ_d = occ_q + 1'b1;
      2'b01:   occ_d = occ_q - 1'b1;
      default: occ_d = occ_q;
    endcase
  end

  // Buffer state registers; reset empties and clears the storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

endmodule

// File: rtl/fifo_burst_reader.sv
// Read-side burst controller for asyn_fifo: issues rinc under a credit rule
// (buffered + in-flight words never exceed BDEPTH), absorbs the one-cycle
// read latency in a small buffer and presents a valid/ready stream.
// Optional sequence checker: define FIFO_BURST_READER_SEQCHK_EN to add O_err.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int DSIZE  = 8,
  parameter int LSIZE  = 16,
  parameter int BDEPTH = BDEPTH_DEF
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_start,
  input  logic [LSIZE-1:0] I_len,
  input  logic             I_rempty,
  output logic             O_rinc,
  input  logic [DSIZE-1:0] I_rdata,
  output logic [DSIZE-1:0] O_data,
  output logic             O_valid,
  input  logic             I_ready,
  output logic             O_busy,
  output logic             O_done
`ifdef FIFO_BURST_READER_SEQCHK_EN
  , output logic           O_err
`endif
);

  localparam int PW = ptr_w(BDEPTH);
  localparam int CW = PW + 2;

  state_t           state_q, state_d;
  logic [LSIZE-1:0] issue_cnt_q, issue_cnt_d;
  logic [LSIZE-1:0] out_cnt_q, out_cnt_d;
  logic             inflight_q, inflight_d;

  logic [PW:0]      occ_s;
  logic             empty_s, full_s;
  logic [DSIZE-1:0] head_s;
  logic [CW-1:0]    credit_s;
  logic             rinc_s, pop_s;

  fifo_burst_reader_sync_buf #(
    .DW    (DSIZE),
    .DEPTH (BDEPTH)
  ) u_sync_buf (
    .clk   (I_clk),
    .rst   (I_rst),
    .push  (inflight_q),
    .din   (I_rdata),
    .pop   (pop_s),
    .dout  (head_s),
    .occ   (occ_s),
    .empty (empty_s),
    .full  (full_s)
  );

  assign credit_s = {1'b0, occ_s} + {{(PW+1){1'b0}}, inflight_q};
  assign pop_s    = !empty_s && I_ready;

  assign O_rinc  = rinc_s;
  assign O_valid = !empty_s;
  assign O_data  = head_s;
  assign O_busy  = (state_q == ST_READ) || (state_q == ST_DRAIN);
  assign O_done  = (state_q == ST_DONE);

  // Burst FSM, read-credit decision and burst counters.
  always_comb begin
    state_d     = state_q;
    issue_cnt_d = issue_cnt_q;
    out_cnt_d   = out_cnt_q;
    rinc_s      = 1'b0;
    if (pop_s && (out_cnt_q != '0)) begin
      out_cnt_d = out_cnt_q - LSIZE'(1);
    end else begin
      out_cnt_d = out_cnt_q;
    end
    case (state_q)
      ST_IDLE: begin
        if (I_start) begin
          if (I_len != '0) begin
            issue_cnt_d = I_len;
            out_cnt_d   = I_len;
            state_d     = ST_READ;
          end else begin
            state_d = ST_DONE;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_READ: begin
        rinc_s = !I_rempty && (issue_cnt_q != '0) &&
                 (credit_s < CW'(BDEPTH)) && !full_s;
        if (rinc_s) begin
          issue_cnt_d = issue_cnt_q - LSIZE'(1);
        end else begin
          issue_cnt_d = issue_cnt_q;
        end
        if (issue_cnt_d == '0) begin
          state_d = ST_DRAIN;
        end else begin
          state_d = ST_READ;
        end
      end
      ST_DRAIN: begin
        if (out_cnt_d == '0) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_DRAIN;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    inflight_d = rinc_s;
  end

  // FSM and counter registers.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q     <= ST_IDLE;
      issue_cnt_q <= '0;
      out_cnt_q   <= '0;
      inflight_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      issue_cnt_q <= issue_cnt_d;
      out_cnt_q   <= out_cnt_d;
      inflight_q  <= inflight_d;
    end
  end

`ifdef FIFO_BURST_READER_SEQCHK_EN
  logic [LSIZE-1:0] exp_q, exp_d;
  logic             err_q, err_d;

  assign O_err = err_q;

  // Expected-word tracking: restart at 1 per burst, flag any out-of-order word.
  always_comb begin
    exp_d = exp_q;
    err_d = err_q;
    if ((state_q == ST_IDLE) && I_start) begin
      exp_d = LSIZE'(1);
    end else if (pop_s) begin
      exp_d = exp_q + LSIZE'(1);
    end else begin
      exp_d = exp_q;
    end
    if (pop_s && (head_s != exp_q[DSIZE-1:0])) begin
      err_d = 1'b1;
    end else begin
      err_d = err_q;
    end
  end

  // Sequence-checker registers; the error flag is sticky until reset.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      exp_q <= '0;
      err_q <= 1'b0;
    end else begin
      exp_q <= exp_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader with a behavioural model of the
// upstream FIFO read port (one-cycle read latency).
module tb_fifo_burst_reader;

  localparam int DSIZE  = 8;
  localparam int LSIZE  = 16;
  localparam int BDEPTH = 4;

  logic             clk = 1'b0;
  logic             I_rst;
  logic             I_start;
  logic [LSIZE-1:0] I_len;
  logic             I_rempty;
  logic             O_rinc;
  logic [DSIZE-1:0] I_rdata;
  logic [DSIZE-1:0] O_data;
  logic             O_valid;
  logic             I_ready;
  logic             O_busy;
  logic             O_done;
`ifdef FIFO_BURST_READER_SEQCHK_EN
  logic             O_err;
`endif

  fifo_burst_reader #(.DSIZE(DSIZE), .LSIZE(LSIZE), .BDEPTH(BDEPTH)) dut (
    .I_clk    (clk),
    .I_rst    (I_rst),
    .I_start  (I_start),
    .I_len    (I_len),
    .I_rempty (I_rempty),
    .O_rinc   (O_rinc),
    .I_rdata  (I_rdata),
    .O_data   (O_data),
    .O_valid  (O_valid),
    .I_ready  (I_ready),
    .O_busy   (O_busy),
    .O_done   (O_done)
`ifdef FIFO_BURST_READER_SEQCHK_EN
    , .O_err  (O_err)
`endif
  );

  always #5 clk = ~clk;

  // Upstream FIFO model: storage written by the stimulus, read on rinc.
  logic [7:0] fmem [256];
  int         wr_idx = 0;
  int         rd_idx = 0;
  logic       fifo_flush;

  assign I_rempty = (wr_idx == rd_idx);

  always @(posedge clk) begin
    if (fifo_flush) begin
      rd_idx <= wr_idx;
    end else if (O_rinc && !I_rempty) begin
      I_rdata <= fmem[rd_idx % 256];
      rd_idx  <= rd_idx + 1;
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc_n = 0;
  int acc_cnt, issued, done_cnt, rinc_cnt, cur_len;
  int first_rinc, first_valid, last_valid, valid_cnt;
  int wr_left, wr_period, wr_val, ready_mode, corrupt_idx;
  logic       prev_stall;
  logic [7:0] prev_data;
  logic       err_exp;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] word_val(input int idx);
    if (idx == corrupt_idx) return 8'hFF;
    return idx[7:0];
  endfunction

  task automatic push_word();
    fmem[wr_idx % 256] = word_val(wr_val);
    wr_idx++;
    wr_val++;
    wr_left--;
  endtask

  // Per-cycle observation of the stream and the read port.
  task automatic monitor();
`ifdef FIFO_BURST_READER_SEQCHK_EN
    chk("seq_err", O_err, err_exp);
`endif
    chk("occ_bound", (issued - acc_cnt) <= BDEPTH, 1);
    if (O_rinc) begin
      chk("rinc_vs_empty", I_rempty, 0);
      chk("rinc_credit", (issued - acc_cnt) < BDEPTH, 1);
      if (rinc_cnt == 0) first_rinc = cyc_n;
      issued++;
      rinc_cnt++;
    end
    if (prev_stall) begin
      chk("hold_valid", O_valid, 1);
      chk("hold_data", O_data, prev_data);
    end
    if (O_valid) begin
      valid_cnt++;
      if (valid_cnt == 1) first_valid = cyc_n;
      last_valid = cyc_n;
    end
    if (O_valid && I_ready) begin
      chk("data_order", O_data, word_val(acc_cnt + 1));
      acc_cnt++;
      if (acc_cnt == corrupt_idx) err_exp = 1'b1;
    end
    prev_stall = O_valid && !I_ready;
    prev_data  = O_data;
    if (O_done) begin
      done_cnt++;
      chk("done_after_last", acc_cnt, cur_len);
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    monitor();
    @(posedge clk);
    #1;
    cyc_n++;
    if (wr_left > 0 && (cyc_n % wr_period) == 0) push_word();
    if (ready_mode == 0) I_ready = 1'b1;
    else I_ready = ((cyc_n % 4) == 0) || ((cyc_n % 4) == 3);
  endtask

  task automatic clear_stats(input int len);
    acc_cnt = 0; issued = 0; done_cnt = 0; rinc_cnt = 0; valid_cnt = 0;
    first_rinc = 0; first_valid = 0; last_valid = 0;
    prev_stall = 1'b0; cur_len = len;
  endtask

  task automatic start_burst(input int len, input int preload, input int period, input int rmode);
    clear_stats(len);
    wr_val = 1; wr_left = len; wr_period = period; ready_mode = rmode;
    for (int i = 0; i < preload; i++) push_word();
    I_start = 1'b1;
    I_len   = len[LSIZE-1:0];
    cyc();
    I_start = 1'b0;
    chk("busy_in_burst", O_busy, 1);
  endtask

  task automatic finish_burst(input string tag, input int budget);
    int n;
    n = 0;
    while (done_cnt == 0 && n < budget) begin
      cyc();
      n++;
    end
    chk({tag, "_done_seen"}, done_cnt > 0, 1);
    repeat (3) cyc();
    chk({tag, "_done_once"}, done_cnt, 1);
    chk({tag, "_word_count"}, acc_cnt, cur_len);
    chk({tag, "_busy_after"}, O_busy, 0);
    chk({tag, "_valid_after"}, O_valid, 0);
  endtask

  initial begin
    int n;
    I_rst = 1'b1; fifo_flush = 1'b0; I_start = 1'b0; I_len = '0; I_ready = 1'b0;
    corrupt_idx = 0; err_exp = 1'b0; wr_left = 0; wr_period = 1; ready_mode = 0;
    clear_stats(0);
    #1;
    chk("rst_rinc", O_rinc, 0);
    chk("rst_valid", O_valid, 0);
    chk("rst_data", O_data, 0);
    chk("rst_busy", O_busy, 0);
    chk("rst_done", O_done, 0);
    repeat (2) @(posedge clk);
    #1;
    I_rst = 1'b0;
    repeat (2) cyc();

    // Basic burst: writer slower than the reader.
    start_burst(30, 0, 3, 0);
    finish_burst("basic", 200);

    // Back-pressure with ready pattern 1-0-0-1.
    start_burst(16, 16, 1, 1);
    finish_burst("bp", 200);

    // Throughput: preloaded FIFO, ready held high.
    start_burst(64, 64, 1, 0);
    finish_burst("tp", 200);
    chk("tp_valid_cnt", valid_cnt, 64);
    chk("tp_contiguous", last_valid - first_valid + 1, 64);
    chk("tp_latency", first_valid - first_rinc, 2);

    // Empty stall: one word every 8 cycles.
    start_burst(10, 0, 8, 0);
    finish_burst("stall", 200);
    chk("stall_rinc_cnt", rinc_cnt, 10);

    // Zero length: done on the following cycle, no reads.
    clear_stats(0);
    I_start = 1'b1;
    I_len   = '0;
    cyc();
    I_start = 1'b0;
    chk("zero_done", O_done, 1);
    chk("zero_busy", O_busy, 0);
    cyc();
    chk("zero_done_drop", O_done, 0);
    cyc();
    chk("zero_no_rinc", rinc_cnt, 0);
    chk("zero_done_cnt", done_cnt, 1);

    // Reset in the middle of a burst after 5 words.
    start_burst(20, 20, 1, 0);
    n = 0;
    while (acc_cnt < 5 && n < 50) begin
      cyc();
      n++;
    end
    chk("mid_reached_5", acc_cnt >= 5, 1);
    I_rst = 1'b1;
    fifo_flush = 1'b1;
    #1;
    chk("mid_rst_rinc", O_rinc, 0);
    chk("mid_rst_valid", O_valid, 0);
    chk("mid_rst_data", O_data, 0);
    chk("mid_rst_busy", O_busy, 0);
    chk("mid_rst_done", O_done, 0);
    clear_stats(0);
    err_exp = 1'b0;
    repeat (2) cyc();
    I_rst = 1'b0;
    fifo_flush = 1'b0;
    cyc();
    chk("post_rst_idle", O_busy, 0);
    start_burst(5, 5, 1, 0);
    finish_burst("post_rst", 100);

`ifdef FIFO_BURST_READER_SEQCHK_EN
    // Corrupted word 7 must raise the sticky error flag.
    corrupt_idx = 7;
    start_burst(10, 10, 1, 0);
    finish_burst("seqchk", 100);
    chk("seqchk_sticky", O_err, 1);
    corrupt_idx = 0;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
